conv3d_cfg_sequencer: RTL and testbench

Config-bus initiator for the conv3d engine. Buffers host (addr, data) register writes in a FIFO and replays them onto the engine's config write port, one per cycle. After a run trigger, it holds off until the engine reports done, then writes the trigger register back to 0 so the engine's rising-edge detector re-arms. This lets software queue a whole layer (or several) without polling between writes.

---
 rtl/conv3d_cfg_sequencer.sv | 144 ++++++++++++++
 tb/tb_conv3d_cfg_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3d_cfg_sequencer.sv
// Config-bus initiator for the conv3d engine: queues host register writes and replays
// them one per cycle, auto-clearing run/prefetch triggers once the engine reports done.
module conv3d_cfg_sequencer #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [5:0]    s_addr,
  input  logic [31:0]   s_data,
  output logic          config_ena,
  output logic [5:0]    config_addr,
  output logic [31:0]   config_data,
  input  logic          conv_done,
  input  logic          prefetch_done,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_CONV = 2'd1;
  localparam logic [1:0] ST_WAIT_PF   = 2'd2;
  localparam logic [1:0] ST_CLEAR     = 2'd3;
  localparam logic [5:0] ADDR_WPREFETCH = 6'd2;
  localparam logic [5:0] ADDR_CONVRUN   = 6'd19;

  logic [5:0]    mem_addr_r [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [1:0]    state_r, state_nx_s;
  logic [5:0]    clr_tgt_r;
  logic          clear_r;
  logic          iss_valid_r;
  logic [5:0]    iss_addr_r;
  logic [31:0]   iss_data_r;
  logic          push_s, pop_s, is_trig_s;
  logic [5:0]    head_addr_s;
  logic [31:0]   head_data_s;

  assign s_ready     = (level_r != LW'(DEPTH));
  assign push_s      = s_valid && s_ready;
  assign head_addr_s = mem_addr_r[rd_ptr_r];
  assign head_data_s = mem_data_r[rd_ptr_r];
  assign is_trig_s   = head_data_s[0] &&
                       ((head_addr_s == ADDR_WPREFETCH) || (head_addr_s == ADDR_CONVRUN));
  assign fifo_level  = level_r;
  assign busy        = (level_r != {LW{1'b0}}) || (state_r != ST_IDLE) || config_ena || iss_valid_r;

  // Next-state and pop decision; clear_r keeps the cycle of the clear write free of pops.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((level_r != {LW{1'b0}}) && !clear_r) begin
          pop_s = 1'b1;
          if (is_trig_s) begin
            state_nx_s = (head_addr_s == ADDR_CONVRUN) ? ST_WAIT_CONV : ST_WAIT_PF;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_WAIT_CONV: begin
        if (conv_done) state_nx_s = ST_CLEAR;
        else           state_nx_s = ST_WAIT_CONV;
      end
      ST_WAIT_PF: begin
        if (prefetch_done) state_nx_s = ST_CLEAR;
        else               state_nx_s = ST_WAIT_PF;
      end
      ST_CLEAR: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // FIFO storage, not reset: occupancy is tracked by level_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= s_addr;
      mem_data_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM, issue stage and registered config port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      clr_tgt_r   <= 6'd0;
      clear_r     <= 1'b0;
      iss_valid_r <= 1'b0;
      iss_addr_r  <= 6'd0;
      iss_data_r  <= 32'd0;
      config_ena  <= 1'b0;
      config_addr <= 6'd0;
      config_data <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      clear_r     <= (state_r == ST_CLEAR);
      iss_valid_r <= pop_s;
      if (pop_s) begin
        iss_addr_r <= head_addr_s;
        iss_data_r <= head_data_s;
      end
      if (state_r == ST_WAIT_CONV)    clr_tgt_r <= ADDR_CONVRUN;
      else if (state_r == ST_WAIT_PF) clr_tgt_r <= ADDR_WPREFETCH;
      if (state_r == ST_CLEAR) begin
        config_ena  <= 1'b1;
        config_addr <= clr_tgt_r;
        config_data <= 32'd0;
      end else if (iss_valid_r) begin
        config_ena  <= 1'b1;
        config_addr <= iss_addr_r;
        config_data <= iss_data_r;
      end else begin
        config_ena  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv3d_cfg_sequencer.sv
// Directed self-checking bench for conv3d_cfg_sequencer; a passive monitor logs every
// config strobe with its edge number, and each scenario task checks the log it expects.
module tb_conv3d_cfg_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [5:0]  s_addr = 6'd0;
  logic [31:0] s_data = 32'd0;
  logic        config_ena;
  logic [5:0]  config_addr;
  logic [31:0] config_data;
  logic        conv_done = 1'b0;
  logic        prefetch_done = 1'b0;
  logic        busy;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_level = 0;
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];

  conv3d_cfg_sequencer #(.DEPTH(16), .LW(5)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_data(s_data), .config_ena(config_ena), .config_addr(config_addr),
    .config_data(config_data), .conv_done(conv_done), .prefetch_done(prefetch_done),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: edge number of each write is the cyc value just after that edge.
  always @(posedge clk) begin
    #1;
    if (config_ena === 1'b1) begin
      log_addr.push_back(config_addr);
      log_data.push_back(config_data);
      log_cyc.push_back(cyc);
    end
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    max_level = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Leaves s_valid high so consecutive calls are back-to-back; returns the handshake edge.
  task automatic host_write(input logic [5:0] a, input logic [31:0] d, output int k);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_addr  = a;
    s_data  = d;
    n = 0;
    while (s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL host_ready_timeout got s_ready=%b want 1", s_ready);
    end
    @(posedge clk);
    #1;
    k = cyc;
  endtask

  task automatic host_idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse(input bit is_conv, output int d);
    @(negedge clk);
    if (is_conv) conv_done = 1'b1;
    else         prefetch_done = 1'b1;
    @(posedge clk);
    #1;
    d = cyc;
    @(negedge clk);
    conv_done = 1'b0;
    prefetch_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (config_ena !== 1'b0 || config_addr !== 6'd0 || config_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_cfg got ena=%b addr=%0d data=%h want 0/0/0", config_ena, config_addr, config_data);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    checks++;
    if (fifo_level !== 5'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got level=%0d busy=%b ready=%b want 0/0/1", fifo_level, busy, s_ready);
    end
  endtask

  task automatic test_ordinary();
    logic [5:0]  ea [4];
    logic [31:0] ed [4];
    int k0, kk;
    ea = '{6'd10, 6'd11, 6'd15, 6'd17};
    ed = '{32'h100, 32'h200, 32'h20, 32'h400};
    clear_log();
    host_write(ea[0], ed[0], k0);
    for (int i = 1; i < 4; i++) host_write(ea[i], ed[i], kk);
    host_idle();
    wait_cycles(8);
    checks++;
    if (log_addr.size() !== 4) begin
      errors++;
      $display("FAIL ord_count got %0d want 4", log_addr.size());
    end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_cyc[i] !== k0 + 2 + i) begin
        errors++;
        $display("FAIL ord_write%0d got (%0d,%h)@%0d want (%0d,%h)@%0d", i, log_addr[i],
                 log_data[i], log_cyc[i], ea[i], ed[i], k0 + 2 + i);
      end
    end
    checks++;
    if (max_level < 1 || max_level > 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ord_level_busy got peak=%0d busy=%b want 1..4/0", max_level, busy);
    end
  endtask

  task automatic test_conv_wait();
    int k, d;
    clear_log();
    host_write(6'd19, 32'h1, k);
    host_write(6'd10, 32'hAA, k);
    host_idle();
    wait_cycles(20);
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 6'd19 || log_data[0] !== 32'h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL conv_wait got n=%0d first=(%0d,%h) busy=%b want 1 (19,1) busy=1",
               log_addr.size(), log_addr[0], log_data[0], busy);
    end
    pulse(1'b1, d);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL conv_busy_clear got %b want 1", busy);
    end
    wait_cycles(8);
    checks++;
    if (log_addr.size() !== 3 || log_addr[1] !== 6'd19 || log_data[1] !== 32'h0 || log_cyc[1] !== d + 1) begin
      errors++;
      $display("FAIL conv_clear got n=%0d (%0d,%h)@%0d want 3 (19,0)@%0d",
               log_addr.size(), log_addr[1], log_data[1], log_cyc[1], d + 1);
    end
    checks++;
    if (log_addr[2] !== 6'd10 || log_data[2] !== 32'hAA || log_cyc[2] < d + 4) begin
      errors++;
      $display("FAIL conv_next got (%0d,%h)@%0d want (10,aa)@>=%0d", log_addr[2], log_data[2],
               log_cyc[2], d + 4);
    end
  endtask

  task automatic test_prefetch();
    int k, d, p;
    clear_log();
    host_write(6'd2, 32'h1, k);
    host_idle();
    wait_cycles(5);
    pulse(1'b1, d);
    wait_cycles(5);
    checks++;
    if (log_addr.size() !== 1 || log_addr[0] !== 6'd2 || log_data[0] !== 32'h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pf_ignore_conv got n=%0d (%0d,%h) busy=%b want 1 (2,1) busy=1",
               log_addr.size(), log_addr[0], log_data[0], busy);
    end
    pulse(1'b0, p);
    wait_cycles(4);
    checks++;
    if (log_addr.size() !== 2 || log_addr[1] !== 6'd2 || log_data[1] !== 32'h0 || log_cyc[1] !== p + 1) begin
      errors++;
      $display("FAIL pf_clear got n=%0d (%0d,%h)@%0d want 2 (2,0)@%0d",
               log_addr.size(), log_addr[1], log_data[1], log_cyc[1], p + 1);
    end
  endtask

  task automatic test_fill();
    int k, d;
    clear_log();
    host_write(6'd19, 32'h1, k);
    host_idle();
    wait_cycles(4);
    for (int i = 0; i < 16; i++) host_write(6'(20 + i), 32'h1000 + 32'(i), k);
    s_valid = 1'b1;
    s_addr  = 6'd40;
    s_data  = 32'hDEAD;
    wait_cycles(3);
    checks++;
    if (fifo_level !== 5'd16 || s_ready !== 1'b0 || log_addr.size() !== 1) begin
      errors++;
      $display("FAIL fill_full got level=%0d ready=%b n=%0d want 16/0/1", fifo_level, s_ready, log_addr.size());
    end
    host_idle();
    pulse(1'b1, d);
    wait_cycles(30);
    checks++;
    if (log_addr.size() !== 18 || log_addr[1] !== 6'd19 || log_data[1] !== 32'h0) begin
      errors++;
      $display("FAIL fill_count got n=%0d clear=(%0d,%h) want 18 (19,0)", log_addr.size(), log_addr[1], log_data[1]);
    end
    for (int i = 0; i < 16 && i + 2 < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i + 2] !== 6'(20 + i) || log_data[i + 2] !== 32'h1000 + 32'(i)) begin
        errors++;
        $display("FAIL fill_drain%0d got (%0d,%h) want (%0d,%h)", i, log_addr[i + 2], log_data[i + 2],
                 20 + i, 32'h1000 + i);
      end
    end
  endtask

  task automatic test_passthru();
    int k0, k;
    clear_log();
    host_write(6'd19, 32'h0, k0);
    host_write(6'd2, 32'h0, k);
    host_idle();
    wait_cycles(6);
    checks++;
    if (log_addr.size() !== 2 || log_addr[0] !== 6'd19 || log_addr[1] !== 6'd2 ||
        log_cyc[0] !== k0 + 2 || log_cyc[1] !== k0 + 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL passthru got n=%0d %0d@%0d %0d@%0d busy=%b want 2 19@%0d 2@%0d busy=0",
               log_addr.size(), log_addr[0], log_cyc[0], log_addr[1], log_cyc[1], busy, k0 + 2, k0 + 3);
    end
  endtask

  task automatic test_reset_mid();
    int k, d;
    clear_log();
    host_write(6'd19, 32'h1, k);
    for (int i = 0; i < 5; i++) host_write(6'(30 + i), 32'h500 + 32'(i), k);
    host_idle();
    wait_cycles(3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (config_ena !== 1'b0 || config_addr !== 6'd0 || config_data !== 32'd0 ||
        fifo_level !== 5'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got ena=%b addr=%0d data=%h level=%0d busy=%b ready=%b want 0/0/0/0/0/1",
               config_ena, config_addr, config_data, fifo_level, busy, s_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(3);
    pulse(1'b1, d);
    wait_cycles(5);
    checks++;
    if (log_addr.size() !== 1) begin
      errors++;
      $display("FAIL rst_no_strobe got n=%0d want 1", log_addr.size());
    end
    host_write(6'd12, 32'h55, k);
    host_idle();
    wait_cycles(4);
    checks++;
    if (log_addr.size() !== 2 || log_addr[1] !== 6'd12 || log_data[1] !== 32'h55 || log_cyc[1] !== k + 2) begin
      errors++;
      $display("FAIL rst_after got n=%0d (%0d,%h)@%0d want 2 (12,55)@%0d",
               log_addr.size(), log_addr[1], log_data[1], log_cyc[1], k + 2);
    end
  endtask

  initial begin
    test_reset();
    test_ordinary();
    test_conv_wait();
    test_prefetch();
    test_fill();
    test_passthru();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
